// File: rtl/jt49_cmd_pkg.sv
// Shared definitions for the jt49 command player: opcodes, command word
// field offsets and the sequencer state encoding.
package jt49_cmd_pkg;

    localparam logic [3:0] OP_END  = 4'hE;
    localparam logic [3:0] OP_WAIT = 4'hF;

    // Command word layout: {chip, op[3:0], data[7:0]}
    localparam int DATA_LSB = 0;
    localparam int OP_LSB   = 8;
    localparam int CHIP_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_STROBE,
        ST_WAIT,
        ST_ADV
    } state_t;

    function automatic logic is_write(input logic [3:0] op);
        return op < OP_END;
    endfunction

endpackage

// File: rtl/jt49_cmd_mem.sv
// Command memory: one synchronous write port, one registered read port.
// The array has no reset so its contents survive a sequencer reset.
module jt49_cmd_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int CW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data
);

    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jt49_cmd_player.sv
// Replays a loadable list of PSG register writes and timed waits into one or
// more jt49 write ports, advancing only on the PSG clock enable.
module jt49_cmd_player
    import jt49_cmd_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int NCHIP      = 1,
    parameter int WAIT_SHIFT = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CHW       = (NCHIP > 1) ? $clog2(NCHIP) : 1,
    localparam int CW        = 12 + CHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             start,
    input  logic             abort,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [CW-1:0]    prog_data,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    cmd_ptr,
    output logic [3:0]       addr,
    output logic [7:0]       din,
    output logic             wr_n,
    output logic [NCHIP-1:0] cs_n
);

    localparam int CNTW = 8 + WAIT_SHIFT;
    localparam logic [CHW:0] NCHIP_W = (CHW+1)'(NCHIP);

    state_t          state, state_nx;
    logic [AW-1:0]   cmd_ptr_nx;
    logic [3:0]      addr_nx;
    logic [7:0]      din_nx;
    logic            wr_n_nx;
    logic [NCHIP-1:0] cs_n_nx;
    logic            done_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic            pend, pend_nx;

    logic [CW-1:0]    cmd;
    logic [CHW-1:0]   cmd_chip;
    logic [3:0]       cmd_op;
    logic [7:0]       cmd_data;
    logic [NCHIP-1:0] chip_sel;
    logic             chip_ok;
    logic             in_idle;
    logic             go;

    assign in_idle  = (state == ST_IDLE);
    assign busy     = !in_idle;
    assign cmd_chip = cmd[CHIP_LSB +: CHW];
    assign cmd_op   = cmd[OP_LSB +: 4];
    assign cmd_data = cmd[DATA_LSB +: 8];
    assign chip_ok  = {1'b0, cmd_chip} < NCHIP_W;
    assign go       = in_idle && cen && !abort && (start || pend);

    // Program writes are only honoured while the sequencer is idle.
    jt49_cmd_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_mem (
        .clk     (clk),
        .we      (prog_we && in_idle),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .re      (cen && (state == ST_FETCH)),
        .rd_addr (cmd_ptr),
        .rd_data (cmd)
    );

    always_comb begin
        chip_sel = '1;
        for (int i = 0; i < NCHIP; i++) begin
            if (cmd_chip == CHW'(i)) begin
                chip_sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cmd_ptr <= '0;
            addr    <= '0;
            din     <= '0;
            wr_n    <= 1'b1;
            cs_n    <= '1;
            done    <= 1'b0;
            cnt     <= '0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nx;
            cmd_ptr <= cmd_ptr_nx;
            addr    <= addr_nx;
            din     <= din_nx;
            wr_n    <= wr_n_nx;
            cs_n    <= cs_n_nx;
            done    <= done_nx;
            cnt     <= cnt_nx;
            pend    <= pend_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cmd_ptr_nx = cmd_ptr;
        addr_nx    = addr;
        din_nx     = din;
        wr_n_nx    = wr_n;
        cs_n_nx    = cs_n;
        done_nx    = done;
        cnt_nx     = cnt;
        pend_nx    = pend || (start && in_idle);

        if (abort) begin
            state_nx = ST_IDLE;
            wr_n_nx  = 1'b1;
            cs_n_nx  = '1;
            done_nx  = 1'b0;
            pend_nx  = 1'b0;
        end else if (cen) begin
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        cmd_ptr_nx = '0;
                        done_nx    = 1'b0;
                        pend_nx    = 1'b0;
                        state_nx   = ST_FETCH;
                    end
                end
                ST_FETCH: state_nx = ST_DECODE;
                ST_DECODE: begin
                    if (is_write(cmd_op)) begin
                        if (chip_ok) begin
                            addr_nx  = cmd_op;
                            din_nx   = cmd_data;
                            wr_n_nx  = 1'b0;
                            cs_n_nx  = chip_sel;
                            state_nx = ST_STROBE;
                        end else begin
                            state_nx = ST_ADV;
                        end
                    end else if (cmd_op == OP_WAIT) begin
                        cnt_nx   = CNTW'(cmd_data) << WAIT_SHIFT;
                        state_nx = ST_WAIT;
                    end else if (cmd_data[0]) begin
                        cmd_ptr_nx = '0;
                        state_nx   = ST_FETCH;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_STROBE: begin
                    wr_n_nx  = 1'b1;
                    state_nx = ST_ADV;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state_nx = ST_ADV;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_ADV: begin
                    // Chip select is released one cen after wr_n rises.
                    cs_n_nx = '1;
                    if (cmd_ptr == AW'(DEPTH - 1)) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        cmd_ptr_nx = cmd_ptr + 1'b1;
                        state_nx   = ST_FETCH;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_cmd_player.sv
// Directed bench for jt49_cmd_player: one 64-entry/3-chip instance and one
// 4-entry/1-chip instance driven from a single linear sequence.
module tb_jt49_cmd_player;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0, we_a = 1'b0;
    logic [5:0]  paddr_a = '0;
    logic [13:0] pdata_a = '0;
    logic        busy_a, done_a, wr_n_a;
    logic [5:0]  ptr_a;
    logic [3:0]  addr_a;
    logic [7:0]  din_a;
    logic [2:0]  cs_n_a;

    logic        start_b = 1'b0, abort_b = 1'b0, we_b = 1'b0;
    logic [1:0]  paddr_b = '0;
    logic [12:0] pdata_b = '0;
    logic        busy_b, done_b, wr_n_b;
    logic [1:0]  ptr_b;
    logic [3:0]  addr_b;
    logic [7:0]  din_b;
    logic [0:0]  cs_n_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic sel_b = 1'b0;
    logic slow = 1'b0;

    int          fall_cyc[$];
    int          rise_cyc[$];
    logic [2:0]  rise_cs[$];
    logic [14:0] obs_q[$];
    logic [14:0] exp_q[$];

    logic       prev_wr_n = 1'b1;
    logic       m_wr;
    logic [2:0] m_cs;
    logic [3:0] m_addr;
    logic [7:0] m_din;

    always #5 clk = ~clk;

    jt49_cmd_player #(.DEPTH(64), .NCHIP(3), .WAIT_SHIFT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start_a), .abort(abort_a),
        .prog_we(we_a), .prog_addr(paddr_a), .prog_data(pdata_a),
        .busy(busy_a), .done(done_a), .cmd_ptr(ptr_a), .addr(addr_a),
        .din(din_a), .wr_n(wr_n_a), .cs_n(cs_n_a)
    );

    jt49_cmd_player #(.DEPTH(4), .NCHIP(1), .WAIT_SHIFT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start_b), .abort(abort_b),
        .prog_we(we_b), .prog_addr(paddr_b), .prog_data(pdata_b),
        .busy(busy_b), .done(done_b), .cmd_ptr(ptr_b), .addr(addr_b),
        .din(din_b), .wr_n(wr_n_b), .cs_n(cs_n_b)
    );

    // Strobe monitor: logs wr_n edges of the selected instance, then drives cen.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        m_wr   = sel_b ? wr_n_b : wr_n_a;
        m_cs   = sel_b ? {2'b11, cs_n_b} : cs_n_a;
        m_addr = sel_b ? addr_b : addr_a;
        m_din  = sel_b ? din_b : din_a;
        if (prev_wr_n === 1'b1 && m_wr === 1'b0) begin
            fall_cyc.push_back(cyc);
            obs_q.push_back({m_cs, m_addr, m_din});
        end
        if (prev_wr_n === 1'b0 && m_wr === 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_cs.push_back(m_cs);
        end
        prev_wr_n = m_wr;
        cen = !slow || ((cyc + 1) % 4 == 0);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        fall_cyc.delete();
        rise_cyc.delete();
        rise_cs.delete();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic prog_a(input int idx, input logic [1:0] chip, input logic [3:0] op,
                          input logic [7:0] data);
        we_a = 1'b1;
        paddr_a = idx[5:0];
        pdata_a = {chip, op, data};
        step(1);
        we_a = 1'b0;
    endtask

    task automatic prog_b(input int idx, input logic [3:0] op, input logic [7:0] data);
        we_b = 1'b1;
        paddr_b = idx[1:0];
        pdata_b = {1'b0, op, data};
        step(1);
        we_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget, output int c);
        int n = 0;
        while (((b ? done_b : done_a) !== 1'b1) && n < budget) begin
            step(1);
            n++;
        end
        c = cyc;
        chk(b ? "done_b_reached" : "done_a_reached", b ? done_b : done_a, 1);
    endtask

    task automatic check_strobes(input string tag);
        logic [14:0] e;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_strobe%0d", tag, i), obs_q[i], e);
        end
        exp_q.delete();
    endtask

    // Three-write program; every timing scales with the cen period s.
    task automatic run_basic(input int s, input string tag);
        int t0;
        int td;
        clear_log();
        exp_q.push_back({3'b110, 4'h0, 8'h11});
        exp_q.push_back({3'b110, 4'h1, 8'h01});
        exp_q.push_back({3'b110, 4'h7, 8'h38});
        while (s > 1 && (cyc % 4) != 0) step(1);
        t0 = cyc;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(s);
        chk({tag, "_busy_after_start"}, busy_a, 1);
        chk({tag, "_done_cleared"}, done_a, 0);
        wait_done(1'b0, 100 * s, td);
        chk({tag, "_first_fall"}, fall_cyc[0] - t0, 3 * s);
        chk({tag, "_gap01"}, fall_cyc[1] - fall_cyc[0], 4 * s);
        chk({tag, "_gap12"}, fall_cyc[2] - fall_cyc[1], 4 * s);
        chk({tag, "_wr_width"}, rise_cyc[0] - fall_cyc[0], s);
        chk({tag, "_cs_hold_at_rise"}, rise_cs[0], 3'b110);
        chk({tag, "_done_time"}, td - t0, 15 * s);
        chk({tag, "_busy_end"}, busy_a, 0);
        chk({tag, "_ptr_end"}, ptr_a, 3);
        chk({tag, "_cs_idle"}, cs_n_a, 3'b111);
        check_strobes(tag);
    endtask

    initial begin
        int t0;
        int td;
        int n;

        // Reset values, checked while reset is still asserted
        step(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ptr", ptr_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_din", din_a, 0);
        chk("rst_wr_n", wr_n_a, 1);
        chk("rst_cs_n", cs_n_a, 3'b111);
        chk("rst_b_wr_n", wr_n_b, 1);
        rst_n = 1'b1;
        step(2);

        // Basic three-write program at full rate, then cen 1-in-4
        prog_a(0, 2'd0, 4'h0, 8'h11);
        prog_a(1, 2'd0, 4'h1, 8'h01);
        prog_a(2, 2'd0, 4'h7, 8'h38);
        prog_a(3, 2'd0, 4'hE, 8'h00);
        run_basic(1, "basic");
        slow = 1'b1;
        step(4);
        run_basic(4, "slow");
        slow = 1'b0;
        step(4);

        // WAIT 2 (513 wait cycles) and WAIT 0 (one wait cycle) between writes
        prog_a(0, 2'd0, 4'h0, 8'hAA);
        prog_a(1, 2'd0, 4'hF, 8'h02);
        prog_a(2, 2'd0, 4'h1, 8'hBB);
        prog_a(3, 2'd0, 4'hF, 8'h00);
        prog_a(4, 2'd0, 4'h2, 8'hCC);
        prog_a(5, 2'd0, 4'hE, 8'h00);
        clear_log();
        exp_q.push_back({3'b110, 4'h0, 8'hAA});
        exp_q.push_back({3'b110, 4'h1, 8'hBB});
        exp_q.push_back({3'b110, 4'h2, 8'hCC});
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_done(1'b0, 700, td);
        chk("wait2_gap", fall_cyc[1] - fall_cyc[0], 520);
        chk("wait0_gap", fall_cyc[2] - fall_cyc[1], 8);
        chk("wait_done_time", td - fall_cyc[2], 4);
        check_strobes("wait");

        // Chip select decode; chip 3 on a 3-chip build is a silent no-op
        prog_a(0, 2'd1, 4'h3, 8'h55);
        prog_a(1, 2'd3, 4'h4, 8'h66);
        prog_a(2, 2'd2, 4'h5, 8'h77);
        prog_a(3, 2'd0, 4'hE, 8'h00);
        clear_log();
        exp_q.push_back({3'b101, 4'h3, 8'h55});
        exp_q.push_back({3'b011, 4'h5, 8'h77});
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_done(1'b0, 100, td);
        chk("chip_noop_gap", fall_cyc[1] - fall_cyc[0], 7);
        chk("chip_ptr_end", ptr_a, 3);
        check_strobes("chip");

        // Looping program, then abort in the middle of WAIT
        prog_a(0, 2'd0, 4'h0, 8'h12);
        prog_a(1, 2'd0, 4'hF, 8'h01);
        prog_a(2, 2'd0, 4'hE, 8'h01);
        clear_log();
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        n = 0;
        while (fall_cyc.size() < 2 && n < 700) begin
            step(1);
            n++;
        end
        chk("loop_two_strobes", fall_cyc.size(), 2);
        chk("loop_period", fall_cyc[1] - fall_cyc[0], 266);
        chk("loop_repeat_data", obs_q[1], {3'b110, 4'h0, 8'h12});
        chk("loop_done_low", done_a, 0);
        chk("loop_busy", busy_a, 1);
        step(20);
        chk("loop_in_wait_ptr", ptr_a, 1);
        abort_a = 1'b1;
        start_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_wr_n", wr_n_a, 1);
        chk("abort_cs_n", cs_n_a, 3'b111);
        chk("abort_done", done_a, 0);
        step(10);
        chk("abort_start_dropped", busy_a, 0);
        chk("abort_no_more_strobes", fall_cyc.size(), 2);

        // DEPTH=4 without END: implicit END after the last entry
        sel_b = 1'b1;
        prog_b(0, 4'h0, 8'h21);
        prog_b(1, 4'h1, 8'h22);
        prog_b(2, 4'h2, 8'h23);
        prog_b(3, 4'h3, 8'h24);
        for (int r = 0; r < 2; r++) begin
            clear_log();
            exp_q.push_back({3'b110, 4'h0, 8'h21});
            exp_q.push_back({3'b110, 4'h1, 8'h22});
            exp_q.push_back({3'b110, 4'h2, 8'h23});
            exp_q.push_back({3'b110, 4'h3, 8'h24});
            t0 = cyc;
            start_b = 1'b1;
            step(1);
            start_b = 1'b0;
            step(1);
            chk($sformatf("depth4_r%0d_busy", r), busy_b, 1);
            chk($sformatf("depth4_r%0d_done_cleared", r), done_b, 0);
            if (r == 0) begin
                // Dropped while busy; the second pass must replay entry 1 unchanged.
                prog_b(1, 4'h9, 8'hAA);
            end
            wait_done(1'b1, 100, td);
            chk($sformatf("depth4_r%0d_done_time", r), td - t0, 17);
            chk($sformatf("depth4_r%0d_ptr", r), ptr_b, 3);
            chk($sformatf("depth4_r%0d_busy_end", r), busy_b, 0);
            check_strobes($sformatf("depth4_r%0d", r));
        end
        sel_b = 1'b0;

        // Asynchronous reset mid-strobe; memory survives it
        prog_a(0, 2'd0, 4'h0, 8'h12);
        clear_log();
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        n = 0;
        while (wr_n_a !== 1'b0 && n < 20) begin
            step(1);
            n++;
        end
        chk("rst_mid_strobe_seen", wr_n_a, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_n", wr_n_a, 1);
        chk("rst_mid_cs_n", cs_n_a, 3'b111);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_addr", addr_a, 0);
        chk("rst_mid_din", din_a, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        clear_log();
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        n = 0;
        while (fall_cyc.size() < 1 && n < 20) begin
            step(1);
            n++;
        end
        chk("rst_mem_kept", obs_q[0], {3'b110, 4'h0, 8'h12});
        abort_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
